// File: rtl/fpu_lzc_pkg.sv
// Shared types for the leading-zero/one counter: count mode and count-width helper.
package fpu_lzc_pkg;

  typedef enum logic {
    LZC_ZEROS = 1'b0,
    LZC_ONES  = 1'b1
  } lzc_mode_e;

  // Count needs one extra bit so that the all-zeros/all-ones case can report WIDTH.
  function automatic int unsigned lzc_cnt_w(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/lzc_level.sv
// One binary-tree level: merges adjacent node pairs (node 0 = most significant).
module lzc_level #(
  parameter int unsigned NODES = 2,
  parameter int unsigned PW    = 1,
  parameter int unsigned LEVEL = 0
) (
  input  logic [NODES-1:0]      v_in,
  input  logic [NODES*PW-1:0]   p_in,
  output logic [NODES/2-1:0]    v_out,
  output logic [NODES/2*PW-1:0] p_out
);

  // Offset added when the terminating bit sits in the lower half of a pair.
  localparam logic [PW-1:0] HALF = PW'(1) << LEVEL;

  for (genvar i = 0; i < int'(NODES / 2); i++) begin : g_node
    assign v_out[i] = v_in[2*i] | v_in[2*i+1];
    assign p_out[i*PW +: PW] = v_in[2*i] ? p_in[2*i*PW +: PW]
                                         : (p_in[(2*i+1)*PW +: PW] | HALF);
  end

endmodule

// File: rtl/lzc_pipe.sv
// Pipelined leading-zero / leading-one counter with global stall and tag sideband.
// Define LZC_NORM_EN to add the out_norm port (operand shifted left by the count).
module lzc_pipe
  import fpu_lzc_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned TAG_W = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_mode,
  input  logic [TAG_W-1:0]            in_tag,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [lzc_cnt_w(WIDTH)-1:0] out_cnt,
  output logic                        out_all,
  output logic [TAG_W-1:0]            out_tag
`ifdef LZC_NORM_EN
  ,
  output logic [WIDTH-1:0]            out_norm
`endif
);

  localparam int unsigned LV = $clog2(WIDTH);
  localparam int unsigned CW = lzc_cnt_w(WIDTH);

  // True when tree level k closes a pipeline stage (levels spread as evenly as possible).
  function automatic bit is_bnd(input int k);
    for (int s = 0; s < int'(DEPTH); s++) begin
      if (((s + 1) * int'(LV) + int'(DEPTH) - 1) / int'(DEPTH) == k) return 1'b1;
    end
    return 1'b0;
  endfunction

  logic      advance;
  lzc_mode_e mode;
  logic      inv;

  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;
  assign mode     = lzc_mode_e'(in_mode);
  assign inv      = (mode == LZC_ONES);

  for (genvar k = 0; k < int'(LV); k++) begin : g_lvl
    localparam int unsigned N = WIDTH >> k;

    logic [N-1:0]     v;
    logic [N*LV-1:0]  p;
    logic             vld;
    logic [TAG_W-1:0] tag;
`ifdef LZC_NORM_EN
    logic [WIDTH-1:0] data;
`endif

    if (k == 0) begin : g_leaf
      // Leaf i marks a terminating bit, scanning from the MSB down.
      for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
        assign v[i] = in_data[WIDTH-1-i] ^ inv;
      end
      assign p   = '0;
      assign vld = in_valid;
      assign tag = in_tag;
`ifdef LZC_NORM_EN
      assign data = in_data;
`endif
    end else begin : g_node
      logic [N-1:0]    nv;
      logic [N*LV-1:0] np;

      lzc_level #(
        .NODES(2 * N),
        .PW   (LV),
        .LEVEL(k - 1)
      ) u_level (
        .v_in (g_lvl[k-1].v),
        .p_in (g_lvl[k-1].p),
        .v_out(nv),
        .p_out(np)
      );

      if (is_bnd(k)) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            v    <= '0;
            p    <= '0;
            vld  <= 1'b0;
            tag  <= '0;
`ifdef LZC_NORM_EN
            data <= '0;
`endif
          end else if (advance) begin
            v    <= nv;
            p    <= np;
            vld  <= g_lvl[k-1].vld;
            tag  <= g_lvl[k-1].tag;
`ifdef LZC_NORM_EN
            data <= g_lvl[k-1].data;
`endif
          end
        end
      end else begin : g_comb
        assign v    = nv;
        assign p    = np;
        assign vld  = g_lvl[k-1].vld;
        assign tag  = g_lvl[k-1].tag;
`ifdef LZC_NORM_EN
        assign data = g_lvl[k-1].data;
`endif
      end
    end
  end

  // Root level: merges the last two nodes and feeds the output register.
  logic          fv;
  logic [LV-1:0] fp;
  logic [CW-1:0] cnt_c;

  lzc_level #(
    .NODES(2),
    .PW   (LV),
    .LEVEL(LV - 1)
  ) u_level_root (
    .v_in (g_lvl[LV-1].v),
    .p_in (g_lvl[LV-1].p),
    .v_out(fv),
    .p_out(fp)
  );

  assign cnt_c = fv ? {1'b0, fp} : CW'(WIDTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_cnt   <= '0;
      out_all   <= 1'b0;
      out_tag   <= '0;
`ifdef LZC_NORM_EN
      out_norm  <= '0;
`endif
    end else if (advance) begin
      out_valid <= g_lvl[LV-1].vld;
      if (g_lvl[LV-1].vld) begin
        out_cnt  <= cnt_c;
        out_all  <= !fv;
        out_tag  <= g_lvl[LV-1].tag;
`ifdef LZC_NORM_EN
        out_norm <= g_lvl[LV-1].data << cnt_c;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lzc_pipe.sv
// Directed and scoreboarded random checks for lzc_pipe (WIDTH=32, DEPTH=2, TAG_W=4).
module tb_lzc_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_mode;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_cnt;
  logic        out_all;
  logic [3:0]  out_tag;
`ifdef LZC_NORM_EN
  logic [31:0] out_norm;
`endif

  int errs   = 0;
  int checks = 0;
  int rcvd   = 0;

  typedef struct packed {
    logic [5:0]  cnt;
    logic        all;
    logic [3:0]  tag;
    logic [31:0] norm;
  } exp_t;

  exp_t q[$];

  lzc_pipe #(
    .WIDTH(32),
    .DEPTH(2),
    .TAG_W(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cnt  (out_cnt),
    .out_all  (out_all),
    .out_tag  (out_tag)
`ifdef LZC_NORM_EN
    ,
    .out_norm (out_norm)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  function automatic exp_t mk(input int c, input logic a, input logic [3:0] t,
                              input logic [31:0] n);
    exp_t e;
    e.cnt  = 6'(c);
    e.all  = a;
    e.tag  = t;
    e.norm = n;
    return e;
  endfunction

  // Linear MSB-first scan used as the reference for random operands.
  function automatic exp_t model(input logic [31:0] d, input logic m, input logic [3:0] t);
    exp_t e;
    e.cnt = 6'd32;
    for (int i = 31; i >= 0; i--) begin
      if (d[i] != m) begin
        e.cnt = 6'(31 - i);
        break;
      end
    end
    e.all  = (e.cnt == 6'd32);
    e.tag  = t;
    e.norm = (e.cnt == 6'd32) ? 32'h0 : d << e.cnt;
    return e;
  endfunction

  task automatic cmp_out(input string nm, input exp_t e);
    chk({nm, "_cnt"}, out_cnt, e.cnt);
    chk({nm, "_all"}, out_all, e.all);
    chk({nm, "_tag"}, out_tag, e.tag);
`ifdef LZC_NORM_EN
    chk({nm, "_norm"}, out_norm, e.norm);
`endif
  endtask

  // One clock: drive at negedge, sample 1 ns later, then move to the next negedge.
  task automatic cycle_io(input logic v, input logic [31:0] d, input logic m,
                          input logic [3:0] t, input logic rdy, input exp_t e,
                          input string nm, output logic acc, output logic rs);
    exp_t h;
    in_valid  = v;
    in_data   = d;
    in_mode   = m;
    in_tag    = t;
    out_ready = rdy;
    #1;
    rs  = in_ready;
    acc = v && in_ready;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk({nm, "_extra"}, out_valid, 1'b0);
      end else if (rdy) begin
        h = q.pop_front();
        cmp_out(nm, h);
        rcvd++;
      end else begin
        h = q[0];
        cmp_out({nm, "_held"}, h);
      end
    end
    if (acc) q.push_back(e);
    @(negedge clk);
  endtask

  // Single operand through an idle pipe, checking the exact two-cycle latency.
  task automatic single(input logic [31:0] d, input logic m, input logic [3:0] t,
                        input int c, input logic a, input logic [31:0] n, input string nm);
    in_valid  = 1'b1;
    in_data   = d;
    in_mode   = m;
    in_tag    = t;
    out_ready = 1'b1;
    #1;
    chk({nm, "_in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    #1;
    chk({nm, "_lat1"}, out_valid, 1'b0);
    @(negedge clk);
    #1;
    chk({nm, "_valid"}, out_valid, 1'b1);
    cmp_out(nm, mk(c, a, t, n));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic acc, rs, stall;
    int   i, base, sent;
    logic [31:0] d;
    logic        m;
    logic [3:0]  t;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    #3;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_out_cnt", out_cnt, 6'd0);
    chk("reset_out_all", out_all, 1'b0);
    chk("reset_out_tag", out_tag, 4'd0);
`ifdef LZC_NORM_EN
    chk("reset_out_norm", out_norm, 32'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    single(32'h0000_8000, 1'b0, 4'd3,  16, 1'b0, 32'h8000_0000, "mid16");
    single(32'h0000_0000, 1'b0, 4'd1,  32, 1'b1, 32'h0000_0000, "zeros");
    single(32'hFFFF_FFFF, 1'b1, 4'd2,  32, 1'b1, 32'h0000_0000, "ones");
    single(32'hF0FF_FFFF, 1'b1, 4'd4,   4, 1'b0, 32'h0FFF_FFF0, "ones4");
    single(32'h8000_0000, 1'b0, 4'd5,   0, 1'b0, 32'h8000_0000, "msb0");
    single(32'h0000_0001, 1'b0, 4'd6,  31, 1'b0, 32'h8000_0000, "lsb31");
    single(32'hFFFF_FFFE, 1'b1, 4'd7,  31, 1'b0, 32'h0000_0000, "ones31");
    single(32'h7FFF_FFFF, 1'b1, 4'd8,   0, 1'b0, 32'h7FFF_FFFF, "ones0");
    single(32'h0000_0000, 1'b1, 4'd15,  0, 1'b0, 32'h0000_0000, "zero_m1");

    // Eight back-to-back operands with out_ready low for cycles 3..6.
    i    = 0;
    base = rcvd;
    for (int c = 0; c < 30; c++) begin
      stall = (c >= 3 && c <= 6);
      if (i < 8)
        cycle_io(1'b1, 32'h8000_0000 >> (3 * i), 1'b0, 4'(i), !stall,
                 mk(3 * i, 1'b0, 4'(i), 32'h8000_0000), "stall", acc, rs);
      else
        cycle_io(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, mk(0, 1'b0, 4'd0, 32'h0), "stall", acc, rs);
      chk("stall_in_ready", rs, !stall);
      if (acc) i++;
    end
    chk("stall_sent", i, 8);
    chk("stall_rcvd", rcvd - base, 8);
    chk("stall_left", q.size(), 0);

    // Two operands in flight when reset hits; neither may emerge afterwards.
    cycle_io(1'b1, 32'h0001_0000, 1'b0, 4'd1, 1'b1, mk(15, 1'b0, 4'd1, 32'h8000_0000),
             "rst", acc, rs);
    cycle_io(1'b1, 32'h0000_0100, 1'b0, 4'd2, 1'b1, mk(23, 1'b0, 4'd2, 32'h8000_0000),
             "rst", acc, rs);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_cnt", out_cnt, 6'd0);
    chk("rst_out_tag", out_tag, 4'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      #1;
      chk("rst_stale", out_valid, 1'b0);
      @(negedge clk);
    end
    single(32'h00F0_0000, 1'b0, 4'd5, 8, 1'b0, 32'hF000_0000, "rst_next");

    // Random operands with a wide spread of counts and random backpressure.
    sent = 0;
    for (int c = 0; c < 40000 && sent < 10000; c++) begin
      m = 1'($urandom_range(0, 1));
      d = $urandom;
      i = $urandom_range(0, 32);
      d = (i == 32) ? 32'h0 : d >> i;
      if (m) d = ~d;
      t = 4'($urandom_range(0, 15));
      cycle_io($urandom_range(0, 9) < 8, d, m, t, $urandom_range(0, 3) != 0,
               model(d, m, t), "rand", acc, rs);
      if (acc) sent++;
    end
    for (int c = 0; c < 20 && q.size() > 0; c++)
      cycle_io(1'b0, 32'h0, 1'b0, 4'd0, 1'b1, mk(0, 1'b0, 4'd0, 32'h0), "rand", acc, rs);
    chk("rand_sent", sent, 10000);
    chk("rand_left", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
